// File: rtl/minimax_pkg.sv
// Shared types and constants for the minimax writeback path.
package minimax_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  uc;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Flat scoreboard index: microcode bank occupies the upper 32 entries.
    function automatic logic [5:0] sb_idx(input logic uc, input logic [REG_ADDR_W-1:0] addr);
        return {uc, addr};
    endfunction

endpackage

// File: rtl/minimax_wb_fifo.sv
// Synchronous FIFO of writeback requests; extra pointer MSB distinguishes full from empty.
module minimax_wb_fifo
    import minimax_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    wb_req_t     mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer state; storage needs no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_req;
        end
    end

endmodule

// File: rtl/minimax_wb_arb.sv
// Writeback arbiter: ALU results vs. buffered load responses, plus pending-load scoreboard.
// Optional operand bypass outputs (byp_hit/byp_data) are enabled by MINIMAX_WB_BYPASS_EN.
module minimax_wb_arb
    import minimax_pkg::*;
#(
    parameter int LD_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic                  alu_uc,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic                  ld_uc,
    input  logic [XLEN-1:0]       ld_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    input  logic                  iss_uc,
    input  logic [REG_ADDR_W-1:0] q_addr,
    input  logic                  q_uc,
    output logic                  q_pending,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_uc,
    output logic [XLEN-1:0]       wb_data
`ifdef MINIMAX_WB_BYPASS_EN
    ,
    output logic                  byp_hit,
    output logic [XLEN-1:0]       byp_data
`endif
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    wb_req_t               fifo_head_s;
    wb_req_t               ld_req_s;
    logic                  ld_push_s;
    logic                  fifo_pop_s;
    logic                  alu_win_s;
    logic                  win_valid_s;
    wb_req_t               win_req_s;
    logic [SW-1:0]         starve_r;
    logic [SW-1:0]         starve_nxt_s;
    logic [63:0]           sb_r;
    logic [63:0]           sb_nxt_s;
    logic                  wb_we_r;
    logic [REG_ADDR_W-1:0] wb_addr_r;
    logic                  wb_uc_r;
    logic [XLEN-1:0]       wb_data_r;

    assign ld_ready  = !fifo_full_s;
    assign ld_push_s = ld_valid && !fifo_full_s;
    assign ld_req_s  = '{uc: ld_uc, addr: ld_addr, data: ld_data};
    assign alu_ready = !(!fifo_empty_s && (starve_r == STARVE_MAX));
    assign alu_win_s = alu_valid && alu_ready;

    minimax_wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (ld_push_s),
        .push_req (ld_req_s),
        .pop      (fifo_pop_s),
        .head     (fifo_head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    // Winner selection: accepted ALU request first, then FIFO head.
    always_comb begin
        win_valid_s = 1'b0;
        win_req_s   = '0;
        fifo_pop_s  = 1'b0;
        if (alu_win_s) begin
            win_valid_s = 1'b1;
            win_req_s   = '{uc: alu_uc, addr: alu_addr, data: alu_data};
        end else if (!fifo_empty_s) begin
            win_valid_s = 1'b1;
            win_req_s   = fifo_head_s;
            fifo_pop_s  = 1'b1;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Starve counter counts ALU wins over a waiting load and saturates at the limit.
    always_comb begin
        starve_nxt_s = '0;
        if (alu_win_s && !fifo_empty_s) begin
            if (starve_r == STARVE_MAX) begin
                starve_nxt_s = starve_r;
            end else begin
                starve_nxt_s = starve_r + SW'(1);
            end
        end else begin
            starve_nxt_s = '0;
        end
    end

    // Scoreboard update; the set is applied last so it wins over a same-cycle clear.
    always_comb begin
        sb_nxt_s = sb_r;
        if (fifo_pop_s) begin
            sb_nxt_s[sb_idx(fifo_head_s.uc, fifo_head_s.addr)] = 1'b0;
        end else begin
            sb_nxt_s = sb_r;
        end
        if (iss_valid && (iss_addr != 5'd0)) begin
            sb_nxt_s[sb_idx(iss_uc, iss_addr)] = 1'b1;
        end else begin
            sb_nxt_s[0] = 1'b0;
        end
    end

    // State and registered RF write port; x0 winners are consumed without a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_r  <= '0;
            sb_r      <= 64'd0;
            wb_we_r   <= 1'b0;
            wb_addr_r <= 5'd0;
            wb_uc_r   <= 1'b0;
            wb_data_r <= 32'd0;
        end else begin
            starve_r <= starve_nxt_s;
            sb_r     <= sb_nxt_s;
            wb_we_r  <= win_valid_s && (win_req_s.addr != 5'd0);
            if (win_valid_s) begin
                wb_addr_r <= win_req_s.addr;
                wb_uc_r   <= win_req_s.uc;
                wb_data_r <= win_req_s.data;
            end
        end
    end

    assign q_pending = (q_addr != 5'd0) && sb_r[sb_idx(q_uc, q_addr)];
    assign wb_we     = wb_we_r;
    assign wb_addr   = wb_addr_r;
    assign wb_uc     = wb_uc_r;
    assign wb_data   = wb_data_r;

`ifdef MINIMAX_WB_BYPASS_EN
    assign byp_hit  = wb_we_r && ({wb_uc_r, wb_addr_r} == {q_uc, q_addr}) && (q_addr != 5'd0);
    assign byp_data = wb_data_r;
`endif

endmodule

// File: tb/tb_minimax_wb_arb.sv
// Bench for minimax_wb_arb: queue-based reference model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_minimax_wb_arb;

    localparam int LD_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, alu_uc;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready, ld_uc;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        iss_valid, iss_uc;
    logic [4:0]  iss_addr;
    logic [4:0]  q_addr;
    logic        q_uc, q_pending;
    logic        wb_we, wb_uc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    minimax_wb_arb #(.LD_DEPTH(LD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_uc(alu_uc), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_uc(ld_uc), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_uc(iss_uc),
        .q_addr(q_addr), .q_uc(q_uc), .q_pending(q_pending),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_uc(wb_uc), .wb_data(wb_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending loads as a queue, pending registers as a bit set.
    typedef struct packed {
        logic        uc;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit   [63:0] msb;
    int          mstarve;
    logic        m_we;
    logic [4:0]  m_addr;
    logic        m_uc;
    logic [31:0] m_data;
    bit          model_ok = 1'b0;

    // Compare against the model, then advance the model with the inputs the next edge will see.
    always @(negedge clk) begin
        bit   m_ar, m_lr, m_qp, has;
        ent_t w;
        m_ar = !(mq.size() != 0 && mstarve == STARVE_LIMIT);
        m_lr = (mq.size() < LD_DEPTH);
        m_qp = (q_addr != 5'd0) && msb[{q_uc, q_addr}];
        if (model_ok) begin
            chk("cmp_wb_we",     32'(wb_we),     32'(m_we));
            chk("cmp_wb_addr",   32'(wb_addr),   32'(m_addr));
            chk("cmp_wb_uc",     32'(wb_uc),     32'(m_uc));
            chk("cmp_wb_data",   wb_data,        m_data);
            chk("cmp_alu_ready", 32'(alu_ready), 32'(m_ar));
            chk("cmp_ld_ready",  32'(ld_ready),  32'(m_lr));
            chk("cmp_q_pending", 32'(q_pending), 32'(m_qp));
        end
        if (reset) begin
            mq.delete();
            msb = '0; mstarve = 0;
            m_we = 1'b0; m_addr = 5'd0; m_uc = 1'b0; m_data = 32'd0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            has = 1'b0;
            w   = '0;
            if (alu_valid && m_ar) begin
                w = {alu_uc, alu_addr, alu_data};
                has = 1'b1;
                if (mq.size() != 0) mstarve = (mstarve < STARVE_LIMIT) ? mstarve + 1 : mstarve;
                else mstarve = 0;
            end else if (mq.size() != 0) begin
                w = mq.pop_front();
                has = 1'b1;
                mstarve = 0;
                msb[{w.uc, w.addr}] = 1'b0;
            end else begin
                mstarve = 0;
            end
            if (ld_valid && m_lr) mq.push_back({ld_uc, ld_addr, ld_data});
            if (iss_valid && iss_addr != 5'd0) msb[{iss_uc, iss_addr}] = 1'b1;
            if (has) begin
                m_we = (w.addr != 5'd0); m_addr = w.addr; m_uc = w.uc; m_data = w.data;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        alu_addr = 5'd0; alu_uc = 1'b0; alu_data = 32'd0;
        ld_addr = 5'd0; ld_uc = 1'b0; ld_data = 32'd0;
        iss_addr = 5'd0; iss_uc = 1'b0; q_addr = 5'd0; q_uc = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk("rst_wb_we",    32'(wb_we),    32'd0);
        chk("rst_wb_data",  wb_data,       32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);

        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd5; alu_uc = 1'b0; alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready", 32'(alu_ready), 32'd1);
        cyc(); idle();
        #1;
        chk("alu_wb_we",   32'(wb_we),   32'd1);
        chk("alu_wb_addr", 32'(wb_addr), 32'd5);
        chk("alu_wb_uc",   32'(wb_uc),   32'd0);
        chk("alu_wb_data", wb_data,      32'hDEADBEEF);

        // Load path with scoreboard
        cyc();
        iss_valid = 1'b1; iss_addr = 5'd7; iss_uc = 1'b1; q_addr = 5'd7; q_uc = 1'b1;
        cyc(); idle();
        #1 chk("ld_pending_set", 32'(q_pending), 32'd1);
        ld_valid = 1'b1; ld_addr = 5'd7; ld_uc = 1'b1; ld_data = 32'h1234;
        cyc(); idle();
        #1;
        chk("ld_not_yet", 32'(wb_we), 32'd0);
        chk("ld_pending_hold", 32'(q_pending), 32'd1);
        cyc();
        #1;
        chk("ld_wb_we",   32'(wb_we),   32'd1);
        chk("ld_wb_data", wb_data,      32'h1234);
        chk("ld_wb_addr", 32'(wb_addr), 32'd7);
        chk("ld_wb_uc",   32'(wb_uc),   32'd1);
        chk("ld_pending_clr", 32'(q_pending), 32'd0);

        // Starvation: one queued load against a continuous ALU stream
        cyc();
        ld_valid = 1'b1; ld_addr = 5'd9; ld_uc = 1'b0; ld_data = 32'hAAAA0009;
        cyc();
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd12; alu_uc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            alu_data = 32'hC0DE0000 + 32'(i);
            #1 chk("starve_ready", 32'(alu_ready), (i != 8) ? 32'd1 : 32'd0);
            if (i == 8) chk("starve_8th_alu", wb_data, 32'hC0DE0007);
            if (i == 9) begin
                chk("starve_ld_we",   32'(wb_we), 32'd1);
                chk("starve_ld_data", wb_data,    32'hAAAA0009);
            end
            cyc();
        end
        idle();
        cyc();

        // FIFO full: ALU busy while five loads are offered
        alu_addr = 5'd20; alu_uc = 1'b0;
        for (int d = 0; d < 15; d++) begin
            alu_valid = (d <= 9);
            alu_data  = 32'hA0000000 + 32'(d);
            ld_valid  = (d <= 10);
            ld_addr   = 5'd10 + 5'((d < 4) ? d : 4);
            ld_uc     = 1'b0;
            ld_data   = 32'h100 + 32'((d < 4) ? d : 4);
            #1;
            if (d == 4) chk("full_ld_ready4", 32'(ld_ready), 32'd0);
            if (d == 9) begin
                chk("full_ld_ready_pop", 32'(ld_ready), 32'd0);
                chk("full_alu_stall",    32'(alu_ready), 32'd0);
            end
            if (d == 10) chk("full_ld_ready_free", 32'(ld_ready), 32'd1);
            if (d >= 10) chk("full_order", wb_data, 32'h100 + 32'(d - 10));
            cyc();
        end
        idle();
        cyc();

        // x0 suppression and bank independence
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        cyc(); idle();
        #1 chk("x0_alu_we", 32'(wb_we), 32'd0);
        iss_valid = 1'b1; iss_addr = 5'd0; iss_uc = 1'b0; q_addr = 5'd0; q_uc = 1'b0;
        cyc(); idle();
        #1 chk("x0_pending", 32'(q_pending), 32'd0);
        iss_valid = 1'b1; iss_addr = 5'd3; iss_uc = 1'b0;
        cyc();
        iss_uc = 1'b1;
        cyc(); idle();
        ld_valid = 1'b1; ld_addr = 5'd3; ld_uc = 1'b0; ld_data = 32'h30;
        cyc(); idle();
        cyc();
        q_addr = 5'd3; q_uc = 1'b0;
        #1 chk("bank0_cleared", 32'(q_pending), 32'd0);
        q_uc = 1'b1;
        #1 chk("bank1_still", 32'(q_pending), 32'd1);
        ld_valid = 1'b1; ld_addr = 5'd3; ld_uc = 1'b1; ld_data = 32'h31;
        cyc(); idle();
        cyc();
        #1;
        chk("bank1_cleared", 32'(q_pending), 32'd0);
        chk("bank1_wb_data", wb_data, 32'h31);

        // Reset with queued loads and pending bits
        alu_valid = 1'b1; alu_addr = 5'd25; alu_uc = 1'b0; alu_data = 32'h55;
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1'b1; iss_addr = 5'd21 + 5'(k); iss_uc = 1'b1;
            cyc();
        end
        iss_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_addr = 5'd21 + 5'(k); ld_uc = 1'b1; ld_data = 32'hBEEF0000 + 32'(k);
            cyc();
        end
        idle();
        reset = 1'b1;
        cyc(); cyc();
        #1;
        chk("mid_rst_we",       32'(wb_we),    32'd0);
        chk("mid_rst_addr",     32'(wb_addr),  32'd0);
        chk("mid_rst_uc",       32'(wb_uc),    32'd0);
        chk("mid_rst_data",     wb_data,       32'd0);
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            logic [5:0] qi;
            qi = 6'(i);
            q_uc = qi[5]; q_addr = qi[4:0];
            #1 chk("post_rst_pending", 32'(q_pending), 32'd0);
            chk("post_rst_no_wb", 32'(wb_we), 32'd0);
            cyc();
        end
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/minimax_wb_arb.md
Name:
minimax_wb_arb

Overview:
- Writeback arbiter directly upstream of the register file write port.
- Merges two writeback sources into the single RF write port (addrD / new_value / we / rD_microcode):
  - single-cycle ALU results;
  - out-of-order load responses, buffered in a small FIFO.
- Keeps a pending-load scoreboard over both register banks (execution + microcode) so issue logic can detect RAW/WAW hazards.

Parameters:
- LD_DEPTH, 4, load-response FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive ALU wins allowed while FIFO non-empty before forced drain (≥1).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_addr  in  5  ALU destination register.
- alu_uc  in  1  ALU destination in microcode bank.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load response valid.
- ld_ready  out  1  FIFO can accept a load response.
- ld_addr  in  5  load destination register.
- ld_uc  in  1  load destination bank.
- ld_data  in  32  load data.
- iss_valid  in  1  load issued; mark destination pending.
- iss_addr  in  5  issued load destination.
- iss_uc  in  1  issued load bank.
- q_addr  in  5  hazard query register.
- q_uc  in  1  hazard query bank.
- q_pending  out  1  queried register has an outstanding load.
- wb_we  out  1  RF write enable.
- wb_addr  out  5  RF write address.
- wb_uc  out  1  RF write bank select.
- wb_data  out  32  RF write data.

Behaviour:
- Reset:
  - wb_we=0, wb_addr=0, wb_uc=0, wb_data=0.
  - FIFO empty; scoreboard all clear; starve counter 0.
  - Reset mid-operation discards FIFO contents and pending bits.
- Handshakes:
  - ld_ready = !fifo_full.
  - Load accepted on ld_valid&ld_ready.
  - No same-cycle pass-through when full, even if popping.
- ALU handshake:
  - alu_ready = !(fifo_nonempty && starve_cnt==STARVE_LIMIT).
  - ALU accepted on alu_valid&alu_ready.
- Arbitration (per cycle):
  - Accepted ALU request wins.
  - Otherwise FIFO head pops if non-empty.
  - Otherwise idle.
- wb_* outputs are registered, 1-cycle latency: winner's addr/uc/data appear next cycle with wb_we=1.
- x0 suppression: if the winner's addr==0, the winner is still consumed (pop or accept), but wb_we=0 that cycle.
- starve_cnt:
  - Increments when ALU wins while FIFO non-empty.
  - Clears when FIFO pops or FIFO empty.
  - Saturates at STARVE_LIMIT.
- FIFO:
  - Circular with log2(LD_DEPTH)+1-bit pointers.
  - Wrap-around on pointer MSB.
  - Simultaneous push+pop when non-full and non-empty: count unchanged.
  - Push to empty FIFO pops at earliest next cycle.
- Scoreboard: 64 bits indexed {uc,addr}.
  - Set on iss_valid; addr 0 never set.
  - Cleared when a FIFO entry for that {uc,addr} pops.
  - Same-cycle set and clear of the same bit: set wins.
- q_pending = scoreboard[{q_uc,q_addr}], combinational; addr 0 returns 0.
- Issue logic must not issue a second load to a pending register; the block does not detect this.

Optional Feature:
- Macro MINIMAX_WB_BYPASS_EN.
- When defined, adds two outputs:
  - byp_hit (1): wb_we && {wb_uc,wb_addr}=={q_uc,q_addr} && q_addr≠0.
  - byp_data (32): equals wb_data.
- Purpose: lets the operand stage forward the value being written this cycle.
- When undefined: ports are absent; the core stalls one cycle instead.

Decomposition:
- Shared package minimax_pkg holds:
  - REG_ADDR_W=5, XLEN=32;
  - wb_req_t struct {uc, addr[4:0], data[31:0]};
  - scoreboard index helper (uc,addr)→6-bit.
- One natural sub-module: minimax_wb_fifo, a parameterised synchronous FIFO of wb_req_t with full/empty.
- Arbiter, starve counter and scoreboard stay in the top.

Test Plan:
- ALU only: alu_valid, addr 5, data 0xDEADBEEF → next cycle wb_we=1, wb_addr=5, wb_uc=0, wb_data=0xDEADBEEF; alu_ready stays 1.
- Load path:
  - Stimulus: iss addr 7 uc=1; q_addr=7,q_uc=1 → q_pending=1; then ld_valid addr 7 uc=1 data 0x1234, ALU idle.
  - Response: wb_we with data 0x1234 two cycles after ld_valid; q_pending=0 the cycle after pop.
- Starvation:
  - Stimulus: STARVE_LIMIT=8; one load queued; alu_valid held continuously.
  - Response: 8 ALU writes, then alu_ready=0 for one cycle, load written back, alu_ready=1 again.
- FIFO full:
  - Stimulus: ALU busy with starve forced off via an empty-then-refill sequence; push 4 loads.
  - Response: ld_ready=0 after the 4th; 5th held until a pop; 5 writebacks occur in FIFO order.
- x0 and bank checks:
  - ALU addr 0 → wb_we stays 0.
  - iss addr 0 → q_pending(0)=0.
  - Loads to addr 3 uc=0 and uc=1 are tracked independently.
- Reset mid-operation: reset asserted with 3 queued loads and 3 pending bits → all wb_* 0, ld_ready=1, q_pending=0 for every address, no stale writebacks after release.
